// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response channel
// plus the valid/ready instruction channel towards the decoder.
interface instr_fetch_if;
  logic        req_o;
  logic [31:0] addr_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  // master: the fetch stage; slave: memory plus decoder side
  modport master (
    output req_o, addr_o, valid_o, instr_o, pc_o,
    input  gnt_i, rvalid_i, rdata_i, ready_i
  );

  modport slave (
    input  req_o, addr_o, valid_o, instr_o, pc_o,
    output gnt_i, rvalid_i, rdata_i, ready_i
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding memory fetch FSM and a
// small prefetch FIFO of {pc, instr} feeding the decoder.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rstn_i,
  input  logic          branch_i,
  input  logic [31:0]   target_i,
  instr_fetch_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_valid, w_req, w_grant, w_push, w_pop;
  logic [31:0]   w_target;

  assign w_valid  = (r_count != '0);
  assign w_req    = rstn_i && (r_state == S_IDLE) && (r_count < CW'(DEPTH));
  assign w_grant  = w_req && bus.gnt_i;
  // A redirect wins over both FIFO ports in the same cycle.
  assign w_pop    = w_valid && bus.ready_i && !branch_i;
  assign w_push   = (r_state == S_WAIT) && bus.rvalid_i && !branch_i;
  assign w_target = target_i & 32'hFFFF_FFFC;

  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
    w_state_nxt = r_state;
    if (branch_i) begin
      if (bus.rvalid_i && (r_state != S_IDLE)) begin
        w_state_nxt = S_IDLE;
      end else if (w_grant || (r_state == S_WAIT)) begin
        w_state_nxt = S_DISCARD;
      end
    end else begin
      case (r_state)
        S_IDLE:    if (w_grant)      w_state_nxt = S_WAIT;
        S_WAIT:    if (bus.rvalid_i) w_state_nxt = S_IDLE;
        S_DISCARD: if (bus.rvalid_i) w_state_nxt = S_IDLE;
        default:                     w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (branch_i) begin
        r_pc <= w_target;
      end else if (w_grant) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_grant) begin
        r_fetch_pc <= r_pc;
      end
      if (branch_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
      r_fifo_instr[r_wr_ptr] <= bus.rdata_i;
    end
  end

  assign bus.req_o   = w_req;
  assign bus.addr_o  = r_pc;
  assign bus.valid_o = w_valid;
  assign bus.instr_o = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
  assign bus.pc_o    = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-by-cycle vector table covering fetch,
// back-pressure, redirects and PC wrap, then a reset-during-fetch sequence.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        branch_i;
  logic [31:0] target_i;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk      (clk),
    .rstn_i   (rstn_i),
    .branch_i (branch_i),
    .target_i (target_i),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        branch;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                       input logic ready, input logic branch, input logic [31:0] target);
    @(negedge clk);
    bus.gnt_i    = gnt;
    bus.rvalid_i = rvalid;
    bus.rdata_i  = rdata;
    bus.ready_i  = ready;
    branch_i     = branch;
    target_i     = target;
    #1;
  endtask

  function automatic vec_t mk(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                              input logic ready, input logic branch, input logic [31:0] target,
                              input logic req, input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic [31:0] instr);
    vec_t v;
    v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.ready = ready;
    v.branch = branch; v.target = target;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr;
    return v;
  endfunction

  vec_t vecs [26];

  initial begin
    //             gnt rv rdata         rdy br target        | req addr          v  pc            instr
    vecs[0]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,       0, 32'h0,        32'h0);
    vecs[1]  = mk(1, 1, 32'h100,      1, 0, 32'h0,        0, 32'h104,       0, 32'h0,        32'h0);
    vecs[2]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h104,       1, 32'h100,      32'h100);
    vecs[3]  = mk(1, 1, 32'h104,      1, 0, 32'h0,        0, 32'h108,       0, 32'h0,        32'h0);
    vecs[4]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h108,       1, 32'h104,      32'h104);
    vecs[5]  = mk(1, 1, 32'h108,      1, 0, 32'h0,        0, 32'h10C,       0, 32'h0,        32'h0);
    // decoder stalls: FIFO fills to two entries, request stays low, head is stable
    vecs[6]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10C,       1, 32'h108,      32'h108);
    vecs[7]  = mk(1, 1, 32'h10C,      0, 0, 32'h0,        0, 32'h110,       1, 32'h108,      32'h108);
    vecs[8]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h110,       1, 32'h108,      32'h108);
    vecs[9]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h110,       1, 32'h108,      32'h108);
    vecs[10] = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h110,       1, 32'h108,      32'h108);
    vecs[11] = mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h110,       1, 32'h108,      32'h108);
    vecs[12] = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h110,       1, 32'h10C,      32'h10C);
    // redirect with a request outstanding; the late response must be dropped
    vecs[13] = mk(1, 0, 32'h0,        1, 1, 32'h203,      0, 32'h114,       0, 32'h0,        32'h0);
    vecs[14] = mk(1, 1, 32'hDEAD,     1, 0, 32'h0,        0, 32'h200,       0, 32'h0,        32'h0);
    vecs[15] = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h200,       0, 32'h0,        32'h0);
    vecs[16] = mk(1, 1, 32'h200,      0, 0, 32'h0,        0, 32'h204,       0, 32'h0,        32'h0);
    vecs[17] = mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h204,       1, 32'h200,      32'h200);
    // redirect coinciding with a response and a pop
    vecs[18] = mk(1, 1, 32'h204,      1, 1, 32'h300,      0, 32'h208,       1, 32'h200,      32'h200);
    vecs[19] = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h300,       0, 32'h0,        32'h0);
    vecs[20] = mk(1, 1, 32'h300,      1, 0, 32'h0,        0, 32'h304,       0, 32'h0,        32'h0);
    // redirect with a same-cycle grant to the top word, then PC wrap
    vecs[21] = mk(1, 0, 32'h0,        1, 1, 32'hFFFF_FFFF, 1, 32'h304,      1, 32'h300,      32'h300);
    vecs[22] = mk(0, 1, 32'hBAD,      1, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    vecs[23] = mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    vecs[24] = mk(0, 1, 32'hCAFE,     0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0);
    vecs[25] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,         1, 32'hFFFF_FFFC, 32'hCAFE);

    rstn_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("req_in_reset", {31'b0, bus.req_o}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("reset_req",   {31'b0, bus.req_o},   32'd0);
    check("reset_addr",  bus.addr_o,           32'h100);
    check("reset_valid", {31'b0, bus.valid_o}, 32'd0);
    check("reset_instr", bus.instr_o,          32'd0);
    check("reset_pc",    bus.pc_o,             32'd0);
    rstn_i = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready, vecs[i].branch, vecs[i].target);
      check($sformatf("v%0d_req", i),   {31'b0, bus.req_o},   {31'b0, vecs[i].req});
      check($sformatf("v%0d_addr", i),  bus.addr_o,           vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'b0, bus.valid_o}, {31'b0, vecs[i].valid});
      check($sformatf("v%0d_pc", i),    bus.pc_o,             vecs[i].pc);
      check($sformatf("v%0d_instr", i), bus.instr_o,          vecs[i].instr);
    end

    // Reset while a fetch is in flight; the stale response afterwards is ignored.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rw_req_before", {31'b0, bus.req_o}, 32'd1);
    rstn_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rw_req_in_reset", {31'b0, bus.req_o}, 32'd0);
    rstn_i = 1'b1;
    drive(1'b0, 1'b1, 32'hBEEF, 1'b1, 1'b0, 32'h0);
    check("rw_req_after",   {31'b0, bus.req_o},   32'd1);
    check("rw_addr_after",  bus.addr_o,           32'h100);
    check("rw_valid_after", {31'b0, bus.valid_o}, 32'd0);
    check("rw_pc_after",    bus.pc_o,             32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("rw_stale_dropped", {31'b0, bus.valid_o}, 32'd0);
    check("rw_addr_fetch",    bus.addr_o,           32'h100);
    drive(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    check("rw_valid_wait", {31'b0, bus.valid_o}, 32'd0);
    check("rw_addr_next",  bus.addr_o,           32'h104);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rw_valid_first", {31'b0, bus.valid_o}, 32'd1);
    check("rw_pc_first",    bus.pc_o,             32'h100);
    check("rw_instr_first", bus.instr_o,          32'h100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
